binder_sched_hf: RTL and testbench

Round-robin scheduler that shares one `binder_hf` instance among NUM_REQ requesters, such as per-channel encoders binding ID and level hypervectors. Each requester presents two hypervectors with a level request. The scheduler grants one requester at a time, pulses the binder, waits for its `out` strobe, and returns the bound vector with a per-requester `done` pulse. A watchdog aborts any operation whose binder result never arrives.

---
 rtl/hdc_pkg.sv | 14 +
 rtl/binder_hf.sv | 34 +++
 rtl/rr_arbiter_hf.sv | 31 +++
 rtl/binder_sched_hf.sv | 152 +++++++++++++++
 tb/tb_binder_sched_hf.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/hdc_pkg.sv
// Shared types and constants for the hypervector binding blocks.
package hdc_pkg;

    // Default hypervector width in bits.
    localparam int unsigned DEFAULT_DIMENSIONS = 10000;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } bind_sched_state_t;

endpackage

// File: rtl/binder_hf.sv
// Registered XOR binder: samples operands on en, presents the result and a
// one-cycle out strobe on the following cycle.
module binder_hf #(
    parameter int unsigned DIMENSIONS = hdc_pkg::DEFAULT_DIMENSIONS
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en,
    input  logic [DIMENSIONS-1:0] hv1,
    input  logic [DIMENSIONS-1:0] hv2,
    output logic                  out,
    output logic [DIMENSIONS-1:0] hv_out
);

    logic                  out_q;
    logic [DIMENSIONS-1:0] hv_q;

    // Capture the bound vector and strobe one cycle after en.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            out_q <= 1'b0;
            hv_q  <= '0;
        end else begin
            out_q <= en;
            if (en) begin
                hv_q <= hv1 ^ hv2;
            end
        end
    end

    assign out    = out_q;
    assign hv_out = hv_q;

endmodule

// File: rtl/rr_arbiter_hf.sv
// Combinational round-robin pick: first set request at or above ptr, with
// wrap-around. Produces a one-hot grant and the matching binary index.
module rr_arbiter_hf #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned PW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PW-1:0]      idx,
    output logic               valid
);

    // Walk the requesters starting at ptr; the first hit wins.
    always_comb begin
        int unsigned cand;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            if (!valid && req[cand]) begin
                valid     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = PW'(cand);
            end
        end
    end

endmodule

// File: rtl/binder_sched_hf.sv
// Round-robin scheduler sharing one binder_hf among NUM_REQ requesters, with
// a watchdog that aborts operations whose binder result never arrives.
module binder_sched_hf
    import hdc_pkg::*;
#(
    parameter int unsigned DIMENSIONS = DEFAULT_DIMENSIONS,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DIMENSIONS-1:0] hv1_in,
    input  logic [NUM_REQ*DIMENSIONS-1:0] hv2_in,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            done,
    output logic [DIMENSIONS-1:0]         hv_out,
    output logic                          err,
    output logic                          busy
);

    localparam int unsigned PW = $clog2(NUM_REQ);
    localparam int unsigned WW = $clog2(TIMEOUT + 1);

    bind_sched_state_t     state_q, state_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [PW-1:0]         idx_q, idx_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic [NUM_REQ-1:0]    done_q, done_d;
    logic                  err_q, err_d;
    logic [DIMENSIONS-1:0] hv_out_q, hv_out_d;
    logic [DIMENSIONS-1:0] op1_q, op1_d;
    logic [DIMENSIONS-1:0] op2_q, op2_d;
    logic [WW-1:0]         wdog_q, wdog_d;

    logic [NUM_REQ-1:0]    arb_gnt;
    logic [PW-1:0]         arb_idx;
    logic                  arb_valid;
    logic                  bind_en;
    logic                  bind_out;
    logic [DIMENSIONS-1:0] bind_hv;
    logic [PW-1:0]         ptr_next;

    rr_arbiter_hf #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    binder_hf #(
        .DIMENSIONS (DIMENSIONS)
    ) u_binder (
        .clk    (clk),
        .nrst   (nrst),
        .en     (bind_en),
        .hv1    (op1_q),
        .hv2    (op2_q),
        .out    (bind_out),
        .hv_out (bind_hv)
    );

    assign bind_en  = (state_q == ISSUE);
    assign ptr_next = (idx_q == PW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

    // Next-state logic; done/err default low so they only ever pulse.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        err_d    = 1'b0;
        hv_out_d = hv_out_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        wdog_d   = wdog_q;
        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    gnt_d   = arb_gnt;
                    idx_d   = arb_idx;
                    op1_d   = hv1_in[int'(arb_idx)*DIMENSIONS +: DIMENSIONS];
                    op2_d   = hv2_in[int'(arb_idx)*DIMENSIONS +: DIMENSIONS];
                    wdog_d  = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                wdog_d = wdog_q + 1'b1;
                // A result arriving on the timeout cycle still counts as success.
                if (bind_out) begin
                    hv_out_d = bind_hv;
                    done_d   = gnt_q;
                    gnt_d    = '0;
                    ptr_d    = ptr_next;
                    state_d  = IDLE;
                end else if (wdog_q == WW'(TIMEOUT)) begin
                    hv_out_d = '0;
                    done_d   = gnt_q;
                    err_d    = 1'b1;
                    gnt_d    = '0;
                    ptr_d    = ptr_next;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            idx_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            hv_out_q <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            wdog_q   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            hv_out_q <= hv_out_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            wdog_q   <= wdog_d;
        end
    end

    assign gnt    = gnt_q;
    assign done   = done_q;
    assign err    = err_q;
    assign hv_out = hv_out_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_binder_sched_hf.sv
// Self-checking bench for binder_sched_hf: directed scenarios plus randomized
// transactions checked against a transaction-level round-robin model.
module tb_binder_sched_hf;

    localparam int unsigned D  = 5;
    localparam int unsigned NR = 4;
    localparam int unsigned TO = 15;

    logic            clk = 1'b0;
    logic            nrst;
    logic [NR-1:0]   req;
    logic [NR*D-1:0] hv1_in;
    logic [NR*D-1:0] hv2_in;
    logic [NR-1:0]   gnt;
    logic [NR-1:0]   done;
    logic [D-1:0]    hv_out;
    logic            err;
    logic            busy;

    int checks = 0;
    int errors = 0;
    int ptr_m  = 0;  // model's round-robin pointer

    binder_sched_hf #(
        .DIMENSIONS (D),
        .NUM_REQ    (NR),
        .TIMEOUT    (TO)
    ) dut (
        .clk    (clk),
        .nrst   (nrst),
        .req    (req),
        .hv1_in (hv1_in),
        .hv2_in (hv2_in),
        .gnt    (gnt),
        .done   (done),
        .hv_out (hv_out),
        .err    (err),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first requester at or after p, wrapping.
    function automatic int pick(input logic [NR-1:0] r, input int p);
        for (int k = 0; k < NR; k++) begin
            if (r[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    function automatic logic [NR*D-1:0] rnd_vec();
        logic [31:0] t;
        t = $urandom;
        return t[NR*D-1:0];
    endfunction

    // One transaction starting at a negedge in IDLE. mode: 0 hold inputs,
    // 1 overwrite hv inputs with fixed values after grant, 2 randomize all.
    task automatic run_op(input logic [NR-1:0] r, input logic [NR*D-1:0] a,
                          input logic [NR*D-1:0] b, input int mode, input bit tmo,
                          output int g);
        logic [D-1:0]  expv;
        logic [NR-1:0] oh;
        req    = r;
        hv1_in = a;
        hv2_in = b;
        g      = pick(r, ptr_m);
        @(negedge clk);
        if (g < 0) begin
            chk("idle_gnt", gnt, 0);
            chk("idle_busy", busy, 0);
            return;
        end
        expv  = a[g*D +: D] ^ b[g*D +: D];
        oh    = '0;
        oh[g] = 1'b1;
        chk("gnt", gnt, oh);
        chk("busy", busy, 1);
        chk("early_done", done, 0);
        if (mode == 1) begin
            hv1_in = {NR{5'b11111}};
            hv2_in = {NR{5'b10110}};
        end else if (mode == 2) begin
            req    = NR'($urandom_range(0, (1 << NR) - 1));
            hv1_in = rnd_vec();
            hv2_in = rnd_vec();
        end
        if (tmo) begin
            for (int k = 0; k < int'(TO) + 1; k++) begin
                @(negedge clk);
                chk("tmo_wait_done", done, 0);
                chk("tmo_wait_busy", busy, 1);
            end
            @(negedge clk);
            chk("tmo_done", done, oh);
            chk("tmo_err", err, 1);
            chk("tmo_hv", hv_out, 0);
        end else begin
            @(negedge clk);
            chk("wait_done", done, 0);
            @(negedge clk);
            chk("done", done, oh);
            chk("hv_out", hv_out, expv);
            chk("err", err, 0);
        end
        chk("gnt_clear", gnt, 0);
        chk("busy_clear", busy, 0);
        ptr_m = (g + 1) % NR;
    endtask

    initial begin
        int g;
        logic [NR*D-1:0] a, b;

        nrst   = 1'b0;
        req    = '0;
        hv1_in = '0;
        hv2_in = '0;
        #12;
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_hv", hv_out, 0);
        @(negedge clk);
        nrst = 1'b1;

        // All requesters held: grants 0,1,2,3 back to back.
        for (int i = 0; i < NR; i++) begin
            a[i*D +: D] = 5'b00101;
            b[i*D +: D] = 5'(5'b00111 + i);
        end
        for (int i = 0; i < NR; i++) begin
            run_op(4'b1111, a, b, 0, 1'b0, g);
            chk("all_order", g, i);
        end

        // Single request from requester 0.
        a = '0;
        b = '0;
        a[4:0] = 5'b11101;
        b[4:0] = 5'b10010;
        run_op(4'b0001, a, b, 0, 1'b0, g);
        chk("single_hv", hv_out, 5'b01111);

        // Fairness: 2 holds, 0 joins after 2's first done.
        a = rnd_vec();
        b = rnd_vec();
        run_op(4'b0100, a, b, 0, 1'b0, g);
        chk("fair_first", g, 2);
        run_op(4'b0101, a, b, 0, 1'b0, g);
        chk("fair_second", g, 0);
        run_op(4'b0101 & 4'b0100, a, b, 0, 1'b0, g);
        chk("fair_third", g, 2);

        // Timeout with the binder strobe held low.
        force dut.bind_out = 1'b0;
        run_op(4'b0010, rnd_vec(), rnd_vec(), 0, 1'b1, g);
        release dut.bind_out;
        chk("tmo_idx", g, 1);

        // Withdraw before grant.
        req = 4'b0010;
        #1;
        req = 4'b0000;
        @(negedge clk);
        chk("withdraw_gnt", gnt, 0);
        chk("withdraw_busy", busy, 0);

        // Operands latched at grant despite later input changes.
        run_op(4'b1000, rnd_vec(), rnd_vec(), 1, 1'b0, g);

        // Randomized transactions against the model.
        for (int n = 0; n < 40; n++) begin
            run_op(NR'($urandom_range(0, (1 << NR) - 1)), rnd_vec(), rnd_vec(), 2, 1'b0, g);
        end

        // Park the pointer away from 0, then reset in the middle of WAIT.
        run_op(4'b0100, rnd_vec(), rnd_vec(), 0, 1'b0, g);
        req    = 4'b0010;
        hv1_in = rnd_vec();
        hv2_in = rnd_vec();
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b0;
        #1;
        chk("midrst_gnt", gnt, 0);
        chk("midrst_done", done, 0);
        chk("midrst_err", err, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_hv", hv_out, 0);
        req = '0;
        @(negedge clk);
        nrst  = 1'b1;
        ptr_m = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_done", done, 0);
            chk("post_rst_gnt", gnt, 0);
        end
        run_op(4'b1111, rnd_vec(), rnd_vec(), 0, 1'b0, g);
        chk("post_rst_ptr", g, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
